// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-coded FIFO pointer controllers: side selectors and
// width-generic binary/Gray conversion (operands are zero-extended to GRAY_MAX_W).
package gray_pkg;

  localparam int SIDE_WR = 0;
  localparam int SIDE_RD = 1;

  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits at or above w are treated as absent.
  function automatic gray_word_t gray2bin(input gray_word_t g, input int w);
    gray_word_t b;
    logic       acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_ctrl_if.sv
// Per-side FIFO pointer bundle: the FIFO logic is the master, the pointer
// controller the slave.
interface gray_ptr_ctrl_if #(
  parameter int ADDR_W = 4
);

  logic              inc_req;
  logic              inc_ok;
  logic [ADDR_W:0]   remote_gray;
  logic [ADDR_W-1:0] bin_addr;
  logic [ADDR_W:0]   bin_ptr;
  logic [ADDR_W:0]   gray_ptr;
  logic              flag;
  logic [ADDR_W:0]   level;
  logic              almost;

  modport master (
    output inc_req, remote_gray,
    input  inc_ok, bin_addr, bin_ptr, gray_ptr, flag, level, almost
  );

  modport slave (
    input  inc_req, remote_gray,
    output inc_ok, bin_addr, bin_ptr, gray_ptr, flag, level, almost
  );

endinterface

// File: rtl/gray_sync.sv
// Plain flop chain carrying the remote Gray pointer into the local clock domain.
// Gray coding guarantees at most one bit is in flight per remote step.
module gray_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage is cleared, not just the last one, so no stale remote
      // pointer can ripple out after reset and fake an occupancy.
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's old
      // value, giving a true STAGES-deep delay line.
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Gray-coded FIFO pointer controller for one FIFO side (SIDE_WR -> full, SIDE_RD -> empty).
// Optional occupancy/almost outputs are built when GRAY_PTR_LEVEL_EN is defined.
module gray_ptr_ctrl
  import gray_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SIDE        = SIDE_WR,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_TH   = 2
) (
  input logic              clk,
  input logic              rst,
  gray_ptr_ctrl_if.slave   bus
);

  localparam int PW = ADDR_W + 1;
  // Full means the remote pointer is exactly one lap behind: in Gray code that is
  // the top two bits inverted and the rest equal.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  logic [PW-1:0] bin_q, gray_q;
  logic [PW-1:0] bin_nxt, gray_nxt;
  logic [PW-1:0] rsync;
  logic          flag_q, flag_nxt;
  logic [PW-1:0] level_q, level_nxt;
  logic          almost_q, almost_nxt;
  logic          inc_ok;

  gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_remote_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.remote_gray),
    .q   (rsync)
  );

  assign inc_ok = bus.inc_req & ~flag_q;

  // Flag looks at the next local pointer so it is already right the cycle after an increment.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    bin_nxt  = bin_q;
    flag_nxt = 1'b0;
    if (inc_ok) bin_nxt = bin_q + PW'(1);
    gray_nxt = PW'(bin2gray(gray_word_t'(bin_nxt)));
    if (SIDE == SIDE_WR) flag_nxt = (gray_nxt == (rsync ^ FULL_MASK));
    else                 flag_nxt = (gray_nxt == rsync);
  end

`ifdef GRAY_PTR_LEVEL_EN
  localparam int ALMOST_FULL_LVL = (1 << ADDR_W) - ALMOST_TH;

  logic [PW-1:0] rbin;

  always_comb begin
    level_nxt  = '0;
    almost_nxt = 1'b0;
    rbin       = PW'(gray2bin(gray_word_t'(rsync), PW));
    if (SIDE == SIDE_WR) begin
      level_nxt  = bin_nxt - rbin;
      almost_nxt = (32'(level_nxt) >= 32'(ALMOST_FULL_LVL));
    end else begin
      level_nxt  = rbin - bin_nxt;
      almost_nxt = (32'(level_nxt) <= 32'(ALMOST_TH));
    end
  end
`else
  assign level_nxt  = '0;
  assign almost_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      flag_q   <= (SIDE == SIDE_RD);
      level_q  <= '0;
      almost_q <= 1'b0;
    end else begin
      bin_q    <= bin_nxt;
      gray_q   <= gray_nxt;
      flag_q   <= flag_nxt;
      level_q  <= level_nxt;
      almost_q <= almost_nxt;
    end
  end

  assign bus.inc_ok   = inc_ok;
  assign bus.bin_addr = bin_q[ADDR_W-1:0];
  assign bus.bin_ptr  = bin_q;
  assign bus.gray_ptr = gray_q;
  assign bus.flag     = flag_q;
  assign bus.level    = level_q;
  assign bus.almost   = almost_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl: a write-side and a read-side instance checked every cycle
// against a binary-occupancy reference model (level/almost expected only with GRAY_PTR_LEVEL_EN).
module tb_gray_ptr_ctrl;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus, index 0 = write side, 1 = read side.
  logic       inc_req_v  [2];
  logic [4:0] remote_bin_v [2];

  // Reference model: plain binary pointers plus the last two remote samples.
  logic [4:0] m_bin [2];
  logic [4:0] m_h1 [2];
  logic [4:0] m_h2 [2];
  logic [4:0] m_level [2];
  logic       m_flag [2];
  logic       m_almost [2];

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  gray_ptr_ctrl_if #(.ADDR_W(AW)) w_if ();
  gray_ptr_ctrl_if #(.ADDR_W(AW)) r_if ();

  assign w_if.inc_req     = inc_req_v[0];
  assign w_if.remote_gray = to_gray(remote_bin_v[0]);
  assign r_if.inc_req     = inc_req_v[1];
  assign r_if.remote_gray = to_gray(remote_bin_v[1]);

  gray_ptr_ctrl #(.ADDR_W(AW), .SIDE(0), .SYNC_STAGES(2), .ALMOST_TH(2)) u_wr (
    .clk (clk), .rst (rst), .bus (w_if)
  );
  gray_ptr_ctrl #(.ADDR_W(AW), .SIDE(1), .SYNC_STAGES(2), .ALMOST_TH(2)) u_rd (
    .clk (clk), .rst (rst), .bus (r_if)
  );

  function automatic logic [21:0] obs(input int s);
    if (s == 0)
      return {w_if.bin_addr, w_if.bin_ptr, w_if.gray_ptr, w_if.flag, w_if.level, w_if.almost, w_if.inc_ok};
    return {r_if.bin_addr, r_if.bin_ptr, r_if.gray_ptr, r_if.flag, r_if.level, r_if.almost, r_if.inc_ok};
  endfunction

  function automatic logic [21:0] expv(input int s);
    logic [4:0] b;
    b = m_bin[s];
    return {b[3:0], b, to_gray(b), m_flag[s], m_level[s], m_almost[s], inc_req_v[s] & ~m_flag[s]};
  endfunction

  // Advance the model by one edge using the current inputs, then let the DUT take that edge.
  task automatic tick();
    logic       ok;
    logic [4:0] nb, rb, lvl;
    logic       alm;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_bin[s] = '0; m_h1[s] = '0; m_h2[s] = '0;
        m_flag[s] = (s == 1); m_level[s] = '0; m_almost[s] = 1'b0;
      end else begin
        ok = inc_req_v[s] && !m_flag[s];
        nb = m_bin[s] + {4'd0, ok};
        rb = m_h2[s];
        if (s == 0) begin
          lvl = nb - rb;
          m_flag[s] = (lvl == 5'd16);
          alm = (lvl >= 5'd14);
        end else begin
          lvl = rb - nb;
          m_flag[s] = (lvl == 5'd0);
          alm = (lvl <= 5'd2);
        end
`ifdef GRAY_PTR_LEVEL_EN
        m_level[s] = lvl; m_almost[s] = alm;
`else
        m_level[s] = '0; m_almost[s] = 1'b0;
`endif
        m_h2[s] = m_h1[s];
        m_h1[s] = remote_bin_v[s];
        m_bin[s] = nb;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin inc_req_v[s] = 1'b0; remote_bin_v[s] = '0; end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin inc_req_v[s] = 1'b0; remote_bin_v[s] = '0; end
    tick();
    tick();
    total++; if (w_if.bin_ptr !== 5'd0 || w_if.gray_ptr !== 5'd0 || w_if.level !== 5'd0 || w_if.almost !== 1'b0) begin
      bad++; $display("FAIL reset_wr_ptrs got bin=%b gray=%b lvl=%0d alm=%b want all 0", w_if.bin_ptr, w_if.gray_ptr, w_if.level, w_if.almost);
    end
    total++; if (w_if.flag !== 1'b0) begin bad++; $display("FAIL reset_wr_flag got=%b want=0", w_if.flag); end
    total++; if (r_if.bin_ptr !== 5'd0 || r_if.gray_ptr !== 5'd0 || r_if.level !== 5'd0 || r_if.almost !== 1'b0) begin
      bad++; $display("FAIL reset_rd_ptrs got bin=%b gray=%b lvl=%0d alm=%b want all 0", r_if.bin_ptr, r_if.gray_ptr, r_if.level, r_if.almost);
    end
    total++; if (r_if.flag !== 1'b1) begin bad++; $display("FAIL reset_rd_flag got=%b want=1", r_if.flag); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [4:0] e14, e16;
    logic       ealm;
`ifdef GRAY_PTR_LEVEL_EN
    e14 = 5'd14; e16 = 5'd16; ealm = 1'b1;
`else
    e14 = 5'd0;  e16 = 5'd0;  ealm = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 16; i++) begin
      inc_req_v[0] = 1'b1;
      tick();
      total++; if (obs(0) !== expv(0)) begin bad++; $display("FAIL fill_inc i=%0d got=%h want=%h", i, obs(0), expv(0)); end
      inc_req_v[0] = 1'b0;
      tick();
      total++; if (obs(0) !== expv(0)) begin bad++; $display("FAIL fill_idle i=%0d got=%h want=%h", i, obs(0), expv(0)); end
      if (i == 13) begin
        total++; if (w_if.level !== e14 || w_if.almost !== ealm || w_if.flag !== 1'b0) begin
          bad++; $display("FAIL fill_14 got lvl=%0d alm=%b flag=%b want lvl=%0d alm=%b flag=0", w_if.level, w_if.almost, w_if.flag, e14, ealm);
        end
      end
    end
    total++; if (w_if.bin_ptr !== 5'b10000 || w_if.gray_ptr !== 5'b11000 || w_if.flag !== 1'b1 || w_if.level !== e16) begin
      bad++; $display("FAIL fill_full got bin=%b gray=%b flag=%b lvl=%0d want 10000 11000 1 %0d", w_if.bin_ptr, w_if.gray_ptr, w_if.flag, w_if.level, e16);
    end
    inc_req_v[0] = 1'b1;
    #1;
    total++; if (w_if.inc_ok !== 1'b0) begin bad++; $display("FAIL fill_blocked_ok got=%b want=0", w_if.inc_ok); end
    tick();
    total++; if (w_if.bin_ptr !== 5'b10000 || w_if.gray_ptr !== 5'b11000) begin
      bad++; $display("FAIL fill_blocked_ptr got bin=%b gray=%b want 10000 11000", w_if.bin_ptr, w_if.gray_ptr);
    end
    inc_req_v[0] = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0] loc, prev;
    int         budget;
    do_reset();
    loc  = '0;
    prev = r_if.gray_ptr;
    for (int step = 0; step < 32; step++) begin
      remote_bin_v[1] = loc + 5'd1;
      budget = 0;
      while (r_if.flag === 1'b1 && budget < 8) begin
        tick();
        total++; if (obs(1) !== expv(1)) begin bad++; $display("FAIL wrap_wait step=%0d got=%h want=%h", step, obs(1), expv(1)); end
        budget++;
      end
      if (budget >= 8) begin
        total++; bad++; $display("FAIL wrap_timeout step=%0d flag stuck got=1 want=0", step);
      end
      inc_req_v[1] = 1'b1;
      tick();
      total++; if (obs(1) !== expv(1)) begin bad++; $display("FAIL wrap_inc step=%0d got=%h want=%h", step, obs(1), expv(1)); end
      inc_req_v[1] = 1'b0;
      total++; if ($countones(prev ^ r_if.gray_ptr) != 1) begin
        bad++; $display("FAIL wrap_onebit step=%0d got %b->%b want 1-bit change", step, prev, r_if.gray_ptr);
      end
      prev = r_if.gray_ptr;
      loc  = loc + 5'd1;
    end
    total++; if (r_if.bin_ptr !== 5'd0 || r_if.gray_ptr !== 5'd0) begin
      bad++; $display("FAIL wrap_final got bin=%b gray=%b want 0 0", r_if.bin_ptr, r_if.gray_ptr);
    end
  endtask

  task automatic test_drain();
    logic want [3];
    want[0] = 1'b1; want[1] = 1'b1; want[2] = 1'b0;
    do_reset();
    remote_bin_v[1] = 5'd2;
    for (int e = 0; e < 3; e++) begin
      tick();
      total++; if (r_if.flag !== want[e] || obs(1) !== expv(1)) begin
        bad++; $display("FAIL drain_latency edge=%0d got flag=%b want=%b (obs=%h model=%h)", e + 1, r_if.flag, want[e], obs(1), expv(1));
      end
    end
    inc_req_v[1] = 1'b1;
    tick();
    total++; if (r_if.flag !== 1'b0 || r_if.bin_ptr !== 5'd1) begin
      bad++; $display("FAIL drain_inc1 got flag=%b bin=%0d want 0 1", r_if.flag, r_if.bin_ptr);
    end
    tick();
    total++; if (r_if.flag !== 1'b1 || r_if.bin_ptr !== 5'd2 || obs(1) !== expv(1)) begin
      bad++; $display("FAIL drain_inc2 got flag=%b bin=%0d want 1 2", r_if.flag, r_if.bin_ptr);
    end
    tick();
    total++; if (r_if.bin_ptr !== 5'd2 || r_if.inc_ok !== 1'b0) begin
      bad++; $display("FAIL drain_blocked got bin=%0d ok=%b want 2 0", r_if.bin_ptr, r_if.inc_ok);
    end
    inc_req_v[1] = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    remote_bin_v[1] = 5'd10;
    tick(); tick(); tick();
    inc_req_v[0] = 1'b1;
    inc_req_v[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        total++; if (obs(s) !== expv(s)) begin bad++; $display("FAIL midop_inc side=%0d i=%0d got=%h want=%h", s, i, obs(s), expv(s)); end
      end
    end
    total++; if (w_if.bin_ptr !== 5'd7 || r_if.bin_ptr !== 5'd7) begin
      bad++; $display("FAIL midop_seven got wr=%0d rd=%0d want 7 7", w_if.bin_ptr, r_if.bin_ptr);
    end
    rst = 1'b1;
    tick();
    total++; if (w_if.bin_ptr !== 5'd0 || w_if.gray_ptr !== 5'd0 || w_if.flag !== 1'b0 || w_if.level !== 5'd0 || w_if.almost !== 1'b0) begin
      bad++; $display("FAIL midop_wr_reset got bin=%b gray=%b flag=%b lvl=%0d alm=%b want 0 0 0 0 0", w_if.bin_ptr, w_if.gray_ptr, w_if.flag, w_if.level, w_if.almost);
    end
    total++; if (r_if.bin_ptr !== 5'd0 || r_if.gray_ptr !== 5'd0 || r_if.flag !== 1'b1 || r_if.level !== 5'd0 || r_if.almost !== 1'b0) begin
      bad++; $display("FAIL midop_rd_reset got bin=%b gray=%b flag=%b lvl=%0d alm=%b want 0 0 1 0 0", r_if.bin_ptr, r_if.gray_ptr, r_if.flag, r_if.level, r_if.almost);
    end
    rst = 1'b0;
    inc_req_v[0] = 1'b0;
    inc_req_v[1] = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] prev [2];
    logic [4:0] g;
    do_reset();
    prev[0] = w_if.gray_ptr;
    prev[1] = r_if.gray_ptr;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 2; s++) begin
        inc_req_v[s] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 31) == 0)     remote_bin_v[s] = 5'($urandom);
        else if ($urandom_range(0, 3) == 0) remote_bin_v[s] = remote_bin_v[s] + 5'd1;
      end
      tick();
      for (int s = 0; s < 2; s++) begin
        total++; if (obs(s) !== expv(s)) begin bad++; $display("FAIL random side=%0d cyc=%0d got=%h want=%h", s, c, obs(s), expv(s)); end
        g = (s == 0) ? w_if.gray_ptr : r_if.gray_ptr;
        if (g !== prev[s]) begin
          total++; if ($countones(g ^ prev[s]) != 1) begin
            bad++; $display("FAIL random_onebit side=%0d cyc=%0d got %b->%b want 1-bit change", s, c, prev[s], g);
          end
        end
        prev[s] = g;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin inc_req_v[s] = 1'b0; remote_bin_v[s] = '0; end
    @(negedge clk);
    test_reset();
    test_fill();
    test_wrap();
    test_drain();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
